// File: rtl/ws2812_in.sv
// WS2812 line receiver: decodes the single-wire LED stream back into
// 24-bit pixels with in-frame index, latch-gap detection and fault pulses.
//
// Ports:
//   clock        system clock (48 MHz)
//   reset        asynchronous active-high reset, clears all state
//   din          WS2812 serial data, asynchronous to clock
//   pixel_data   last completed pixel, first received bit in [23]
//   pixel_index  position of pixel_data in the current frame, 0-based
//   pixel_strobe one-cycle pulse, pixel_data/pixel_index valid
//   frame_done   one-cycle pulse when a latch gap ends a frame with data
//   error        one-cycle pulse on any framing or protocol fault
`timescale 1ns/1ps

module ws2812_in #(
   parameter int BIT_THRESHOLD = 27,
   parameter int MIN_HIGH      = 4,
   parameter int MAX_HIGH      = 120,
   parameter int RESET_CYCLES  = 2400,
   parameter int INDEX_WIDTH   = 11
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   din,
   output logic [23:0]            pixel_data,
   output logic [INDEX_WIDTH-1:0] pixel_index,
   output logic                   pixel_strobe,
   output logic                   frame_done,
   output logic                   error
);

   localparam logic [1:0] SYNC = 2'd0;
   localparam logic [1:0] IDLE = 2'd1;
   localparam logic [1:0] HIGH = 2'd2;
   localparam logic [1:0] LOW  = 2'd3;

   localparam logic [15:0] THR_C  = 16'(BIT_THRESHOLD);
   localparam logic [15:0] MINH_C = 16'(MIN_HIGH);
   localparam logic [15:0] MAXH_C = 16'(MAX_HIGH);
   localparam logic [15:0] GAP_C  = 16'(RESET_CYCLES);
   localparam logic [15:0] SAT_C  = 16'hFFFF;

   // input synchronizer and edge history
   logic s1;
   logic s2;
   logic s3;
   logic rise;
   logic fall;

   // pulse width counters
   logic [15:0] high_cnt;
   logic [15:0] low_cnt;

   // decoder state
   logic [1:0]             state;
   logic [1:0]             state_n;
   logic [4:0]             bit_count;
   logic [4:0]             bit_count_n;
   logic [INDEX_WIDTH-1:0] pixel_count;
   logic [INDEX_WIDTH-1:0] pixel_count_n;
   logic                   overflow;
   logic                   overflow_n;
   logic                   got_bits;
   logic                   got_bits_n;
   logic [23:0]            shift_reg;
   logic [23:0]            shift_n;

   // per-cycle events from the decoder
   logic gap;
   logic bit_val;
   logic ev_pix;
   logic ev_frame;
   logic ev_err;

   // one registered stage between decode and outputs
   logic                   pix_pend;
   logic                   frame_pend;
   logic                   err_pend;
   logic [23:0]            data_pend;
   logic [INDEX_WIDTH-1:0] idx_pend;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

   // The edge cycle itself is the first clock of the new level, so the
   // counter restarts at 1 and reads exactly the pulse width on the
   // opposite edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         high_cnt <= '0;
      end else if (rise) begin
         high_cnt <= 16'd1;
      end else if (s2 && high_cnt != SAT_C) begin
         high_cnt <= high_cnt + 16'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         low_cnt <= '0;
      end else if (fall) begin
         low_cnt <= 16'd1;
      end else if (!s2 && low_cnt != SAT_C) begin
         low_cnt <= low_cnt + 16'd1;
      end
   end

   // low_cnt passes the gap value exactly once per low stretch
   assign gap     = ~s2 && (low_cnt == GAP_C);
   assign bit_val = (high_cnt >= THR_C);

   always_comb begin
      state_n       = state;
      bit_count_n   = bit_count;
      pixel_count_n = pixel_count;
      overflow_n    = overflow;
      got_bits_n    = got_bits;
      shift_n       = shift_reg;
      ev_pix        = 1'b0;
      ev_frame      = 1'b0;
      ev_err        = 1'b0;
      unique case (state)
         SYNC: begin
            if (gap) begin
               bit_count_n   = '0;
               pixel_count_n = '0;
               overflow_n    = 1'b0;
               got_bits_n    = 1'b0;
               state_n       = IDLE;
            end
         end
         IDLE: begin
            if (rise) begin
               state_n = HIGH;
            end
         end
         HIGH: begin
            if (high_cnt >= MAXH_C) begin
               ev_err  = 1'b1;
               state_n = SYNC;
            end else if (fall) begin
               if (high_cnt < MINH_C) begin
                  ev_err  = 1'b1;
                  state_n = SYNC;
               end else begin
                  shift_n    = {shift_reg[22:0], bit_val};
                  got_bits_n = 1'b1;
                  state_n    = LOW;
                  if (bit_count == 5'd23) begin
                     bit_count_n = '0;
                     if (overflow) begin
                        ev_err = 1'b1;
                     end else begin
                        ev_pix = 1'b1;
                        // last index is sticky: later pixels are dropped
                        if (pixel_count == '1) begin
                           overflow_n = 1'b1;
                        end else begin
                           pixel_count_n = pixel_count + 1'b1;
                        end
                     end
                  end else begin
                     bit_count_n = bit_count + 5'd1;
                  end
               end
            end
         end
         LOW: begin
            if (rise) begin
               state_n = HIGH;
            end else if (gap) begin
               ev_frame      = got_bits;
               ev_err        = (bit_count != 5'd0);
               bit_count_n   = '0;
               pixel_count_n = '0;
               overflow_n    = 1'b0;
               got_bits_n    = 1'b0;
               state_n       = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= SYNC;
         bit_count   <= '0;
         pixel_count <= '0;
         overflow    <= 1'b0;
         got_bits    <= 1'b0;
         shift_reg   <= '0;
      end else begin
         state       <= state_n;
         bit_count   <= bit_count_n;
         pixel_count <= pixel_count_n;
         overflow    <= overflow_n;
         got_bits    <= got_bits_n;
         shift_reg   <= shift_n;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pix_pend   <= 1'b0;
         frame_pend <= 1'b0;
         err_pend   <= 1'b0;
         data_pend  <= '0;
         idx_pend   <= '0;
      end else begin
         pix_pend   <= ev_pix;
         frame_pend <= ev_frame;
         err_pend   <= ev_err;
         if (ev_pix) begin
            data_pend <= shift_n;
            idx_pend  <= pixel_count;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pixel_strobe <= 1'b0;
         frame_done   <= 1'b0;
         error        <= 1'b0;
         pixel_data   <= '0;
         pixel_index  <= '0;
      end else begin
         pixel_strobe <= pix_pend;
         frame_done   <= frame_pend;
         error        <= err_pend;
         if (pix_pend) begin
            pixel_data  <= data_pend;
            pixel_index <= idx_pend;
         end
      end
   end

endmodule

// File: doc/ws2812_in.md
Name: ws2812_in

Overview:
- WS2812 line receiver/decoder. It is the receiving end of the serial stream that ws2812_out produces.
- Samples a single-wire WS2812 data input and classifies each high pulse as a 0 or 1 bit.
- Assembles bits MSB-first into 24-bit pixel words, indexes them within a frame, and detects the latch (reset) gap.
- Used for loopback self-test of the LED output chain and for chaining boards (decode upstream, re-drive downstream).

Parameters:
- BIT_THRESHOLD, 27: high-pulse width in clocks at or above which the bit decodes as 1. At 48 MHz a 0 is about 18 clocks and a 1 about 36.
- MIN_HIGH, 4: high pulses shorter than this are glitches and raise an error.
- MAX_HIGH, 120: a high pulse reaching this many clocks is a line fault.
- RESET_CYCLES, 2400: low time in clocks (50 us at 48 MHz) that constitutes a latch gap.
- INDEX_WIDTH, 11: width of pixel_index. Maximum frame length is 2^INDEX_WIDTH pixels.

Ports:
- clock  input  1  system clock, 48 MHz HFOSC
- reset  input  1  asynchronous, active-high; clears all state
- din  input  1  WS2812 serial data, asynchronous to clock
- pixel_data  output  24  last completed pixel, first-received bit in [23]
- pixel_index  output  INDEX_WIDTH  position of pixel_data within the current frame, 0-based
- pixel_strobe  output  1  one-cycle pulse; pixel_data and pixel_index are valid in that cycle
- frame_done  output  1  one-cycle pulse when a latch gap ends a frame that contained data
- error  output  1  one-cycle pulse on any framing or protocol fault

Behaviour:
- Reset values: pixel_data=0, pixel_index=0, pixel_strobe=0, frame_done=0, error=0. Internally: state=SYNC, counters=0, bit_count=0, pixel_count=0, overflow=0, synchronizer flops=0.
- Input path: din passes through 2-FF synchronizer (s1, s2) plus history flop s3.
  - Rise = s2 & ~s3. Fall = ~s2 & s3.
  - All decisions use s2.
- Counters:
  - high_cnt counts clocks while s2=1; cleared on rise.
  - low_cnt counts clocks while s2=0; cleared on fall.
  - Both are 16-bit and saturate at all-ones.
- States:
  - SYNC: entered after reset and after any fault.
    - Ignores all edges.
    - When low_cnt reaches RESET_CYCLES: clear bit_count, pixel_count and overflow; go to IDLE. No frame_done is issued.
  - IDLE: line low, frame boundary established.
    - Rise -> HIGH.
  - HIGH: measuring a high pulse.
    - If high_cnt reaches MAX_HIGH: pulse error, go to SYNC.
    - On fall with high_cnt < MIN_HIGH: pulse error, go to SYNC.
    - On other fall: bit = (high_cnt >= BIT_THRESHOLD); shift bit into 24-bit shift register at LSB, so the first bit ends in [23]; increment bit_count; go to LOW.
  - LOW: between bits.
    - Rise -> HIGH.
    - When low_cnt reaches RESET_CYCLES, take the latch actions below, then go to IDLE.
- Pixel completion: on the fall that makes bit_count=24, reset bit_count to 0.
  - If overflow=0: next cycle pixel_data=shift register, pixel_index=pixel_count, pixel_strobe=1.
  - Increment pixel_count. If pixel_count was 2^INDEX_WIDTH-1, set overflow instead of wrapping.
  - If overflow=1: pixel is dropped and error pulses.
- Latch actions (LOW, low_cnt = RESET_CYCLES):
  - frame_done pulses for one cycle if any bit was received since the last latch.
  - If bit_count != 0 (partial pixel): error pulses in the same cycle and the partial bits are discarded.
  - Clear bit_count, pixel_count and overflow.
- Latency: pixel_strobe rises on the 4th rising clock edge after the first edge at which din is sampled low ending bit 24 (2 sync + 1 detect + 1 register). frame_done follows the same pipeline relative to the RESET_CYCLES count.
- Simultaneous events:
  - A fall completing a pixel during overflow gives error only.
  - error and frame_done may pulse in the same cycle.
  - pixel_strobe and frame_done never coincide, since a fall and a latch cannot occur in one cycle.
- Asserting reset mid-pulse or mid-frame drops everything. After release, the block waits in SYNC for a full gap, so a partially observed frame is never emitted.

Test Plan:
- Reset release, din low for 2400 clocks, then 24 bits 0xA5C33C, each bit 60 clocks (0: 18 high/42 low; 1: 36 high/24 low), then 3000 clocks low -> one pixel_strobe with pixel_data=0xA5C33C, pixel_index=0; one frame_done; error never high.
- Three pixels 0x000000, 0xFFFFFF, 0x123456 back-to-back, then latch -> strobes with index 0,1,2 and matching data; frame_done once. Second identical frame restarts at index 0.
- Threshold edges: high widths 26 and 28 clocks -> decode 0 and 1 respectively. Width 3 -> error, no strobe until the next 2400-clock gap; the following frame decodes correctly.
- Stuck high for 200 clocks -> error at high_cnt=120, state SYNC; subsequent valid frame after gap decodes at index 0.
- 12 bits then a 3000-clock gap -> error and frame_done in the same cycle, no strobe; next frame pixel_index starts at 0.
- INDEX_WIDTH=2: 5 pixels in one frame -> strobes for indices 0-3, error on the 5th, frame_done at latch. Also assert reset mid-bit: all outputs 0 immediately and no strobe before a full gap.
